// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port 320x240 frame buffer between pixel-doubled VGA scan-out
// and a host write port. Defining VRAM_CLEAR_EN adds a clear-screen sequencer.
module vram_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FB_WORDS = 76800,
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    output logic [DATA_W-1:0] pix_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam logic [9:0]        H_LIM   = 10'(H_ACTIVE);
    localparam logic [9:0]        V_LIM   = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);

    typedef enum logic {IDLE, ACK} wr_state_t;
    wr_state_t wr_state_reg;

    logic              active;
    logic              disp_slot;
    logic              wr_in_range;
    logic              clr_go;
    logic              act_d1_reg;
    logic              act_d2_reg;
    logic              disp_d1_reg;
    logic              disp_d2_reg;
    logic [ADDR_W-1:0] x_half;
    logic [ADDR_W-1:0] y_half;
    logic [ADDR_W-1:0] disp_addr;

    assign active      = (xpos < H_LIM) && (ypos < V_LIM);
    assign disp_slot   = active && !xpos[0];
    assign wr_in_range = wr_addr <= FB_LAST;
    assign x_half      = ADDR_W'(xpos[9:1]);
    assign y_half      = ADDR_W'(ypos[9:1]);
    // y*320 = y*256 + y*64
    assign disp_addr   = (y_half << 8) + (y_half << 6) + x_half;

`ifdef VRAM_CLEAR_EN
    logic              clr_busy_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [DATA_W-1:0] clr_color_reg;

    assign clr_go   = clr_start && !clr_busy_reg && (wr_state_reg == IDLE);
    assign clr_busy = clr_busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_busy_reg  <= 1'b0;
            clr_cnt_reg   <= '0;
            clr_color_reg <= '0;
        end else if (clr_go) begin
            clr_busy_reg  <= 1'b1;
            clr_cnt_reg   <= '0;
            clr_color_reg <= clr_color;
        end else if (clr_busy_reg && !disp_slot) begin
            // Counter stops at the last word; busy drops with the final write.
            if (clr_cnt_reg == FB_LAST)
                clr_busy_reg <= 1'b0;
            else
                clr_cnt_reg <= clr_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = &{1'b0, clr_start, clr_color};
    assign clr_go     = 1'b0;
    assign clr_busy   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_reg <= IDLE;
            wr_ack       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            pix_data     <= '0;
            act_d1_reg   <= 1'b0;
            act_d2_reg   <= 1'b0;
            disp_d1_reg  <= 1'b0;
            disp_d2_reg  <= 1'b0;
        end else begin
            wr_ack      <= 1'b0;
            ram_we      <= 1'b0;
            act_d1_reg  <= active;
            act_d2_reg  <= act_d1_reg;
            disp_d1_reg <= disp_slot;
            disp_d2_reg <= disp_d1_reg;

            // Odd active pixels keep the even pixel's value (horizontal doubling).
            if (disp_d2_reg)
                pix_data <= ram_dout;
            else if (!act_d2_reg)
                pix_data <= '0;

            if (wr_state_reg == ACK)
                wr_state_reg <= IDLE;

            if (disp_slot) begin
                ram_addr <= disp_addr;
            end
`ifdef VRAM_CLEAR_EN
            else if (clr_busy_reg) begin
                ram_addr <= clr_cnt_reg;
                ram_din  <= clr_color_reg;
                ram_we   <= 1'b1;
            end
`endif
            else if (wr_state_reg == IDLE && wr_req && !clr_go) begin
                wr_state_reg <= ACK;
                ram_addr     <= wr_addr;
                ram_din      <= wr_data;
                ram_we       <= wr_in_range;
                wr_ack       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: external RAM plus a frame-level reference model of the pixel
// stream and host-write handshake. Clear tests are included when VRAM_CLEAR_EN is defined.
module tb_vram_arbiter;
    localparam int          FB   = 76800;
    localparam logic [16:0] FB_W = 17'd76800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  xpos = 10'd700;
    logic [9:0]  ypos = 10'd10;
    logic [11:0] pix_data;
    logic        wr_req = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        wr_ack;
    logic        clr_start = 1'b0;
    logic [11:0] clr_color = '0;
    logic        clr_busy;
    logic [16:0] ram_addr;
    logic [11:0] ram_din;
    logic        ram_we;
    logic [11:0] ram_dout = '0;

    vram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .pix_data(pix_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [11:0] ram_mem [0:FB-1];
    logic [11:0] ref_mem [0:FB-1];

    // Single-port synchronous RAM, read-before-write.
    always @(posedge clk) begin
        if (ram_addr < FB_W) begin
            ram_dout <= ram_mem[ram_addr];
            if (ram_we) ram_mem[ram_addr] <= ram_din;
        end else begin
            ram_dout <= '0;
        end
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ack_at = -1;
    bit          ack_we_exp = 1'b0;
    logic [16:0] ack_addr = '0;
    logic [11:0] ack_data = '0;
    int          pq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit pos_active();
        return (xpos < 10'd640) && (ypos < 10'd480);
    endfunction

    function automatic bit pos_free();
        return !(pos_active() && !xpos[0]);
    endfunction

    function automatic logic [16:0] fb_index(input logic [9:0] x, input logic [9:0] y);
        return 17'((int'(y) / 2) * 320 + int'(x) / 2);
    endfunction

    task automatic sync_pixels();
        pq.delete();
        pq.push_back(0);
        pq.push_back(0);
    endtask

    // One clock: record expected pixel, step, check outputs, advance the scan position.
    task automatic tick();
        bit          disp;
        logic [16:0] a;
        disp = pos_active() && !xpos[0];
        a    = fb_index(xpos, ypos);
        pq.push_back(pos_active() ? int'(ref_mem[a]) : 0);
        @(posedge clk);
        #1;
        cyc++;
        chk("pix", pix_data, pq.pop_front());
        chk("ack", wr_ack, cyc == ack_at);
        chk("we", ram_we, (cyc == ack_at) && ack_we_exp);
        chk("busy", clr_busy, 0);
        if (disp) chk("disp_addr", ram_addr, a);
        if (cyc == ack_at) begin
            chk("wr_addr", ram_addr, ack_addr);
            chk("wr_din", ram_din, ack_data);
            if (ack_we_exp) ref_mem[ack_addr] = ack_data;
        end
        if (cyc == ack_at + 1) wr_req = 1'b0;
        if (xpos == 10'd799) begin
            xpos = 10'd0;
            ypos = (ypos == 10'd524) ? 10'd0 : ypos + 10'd1;
        end else begin
            xpos = xpos + 10'd1;
        end
    endtask

    // A DISP cycle is always followed by a FREE odd pixel, so the ack lands 1 or 2 cycles later.
    task automatic host_write(input logic [16:0] a, input logic [11:0] d);
        int lat;
        lat        = pos_free() ? 1 : 2;
        wr_req     = 1'b1;
        wr_addr    = a;
        wr_data    = d;
        ack_at     = cyc + lat;
        ack_addr   = a;
        ack_data   = d;
        ack_we_exp = a < FB_W;
        repeat (lat + 2) tick();
    endtask

    initial begin
        int          got;
        int          errs;
        logic [16:0] ra;
        for (int i = 0; i < FB; i++) begin
            ram_mem[i] = 12'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[321] = 12'hABC;
        ref_mem[321] = 12'hABC;

        // Reset with a write pending
        wr_req = 1'b1; wr_addr = 17'd7; wr_data = 12'h5A5;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_ack", wr_ack, 0);
            chk("rst_we", ram_we, 0);
            chk("rst_pix", pix_data, 0);
            chk("rst_addr", ram_addr, 0);
            chk("rst_din", ram_din, 0);
            chk("rst_busy", clr_busy, 0);
        end
        rst_n = 1'b1;
        cyc = 0;
        sync_pixels();
        host_write(17'd7, 12'h5A5);

        // Display fetch of (2,2) -> word 321, doubled
        xpos = 10'd2; ypos = 10'd2;
        tick();
        chk("t2_addr", ram_addr, 321);
        tick();
        tick();
        chk("t2_pix0", pix_data, 12'hABC);
        tick();
        chk("t2_pix1", pix_data, 12'hABC);

        // Contention with display at an even active pixel, then on a free pixel
        xpos = 10'd100; ypos = 10'd50;
        host_write(17'd5, 12'h123);
        repeat (3) tick();
        host_write(17'd6, 12'h456);

        // Out-of-range addresses: acked, never written
        host_write(17'd76800, 12'hFFF);
        xpos = 10'd200; ypos = 10'd60;
        host_write(17'd100000, 12'hEEE);

        // Host writes to words about to be displayed
        xpos = 10'd40; ypos = 10'd20;
        host_write(fb_index(10'd48, 10'd20), 12'h7E7);
        host_write(fb_index(10'd52, 10'd20), 12'h1C1);
        repeat (12) tick();

        // Right and bottom edges of the active area
        xpos = 10'd632; ypos = 10'd479;
        repeat (20) tick();
        xpos = 10'd636; ypos = 10'd478;
        host_write(17'd76799, 12'h3C3);
        repeat (8) tick();
        xpos = 10'd0; ypos = 10'd479;
        repeat (6) tick();
        chk("last_word", ref_mem[76799], ram_mem[76799]);

        // Randomized segments of scan with interleaved host writes
        for (int seg = 0; seg < 40; seg++) begin
            xpos = 10'($urandom_range(0, 399) * 2);
            ypos = 10'($urandom_range(0, 524));
            for (int k = 0; k < int'($urandom_range(4, 24)); k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ra = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(76800, 131071))
                                                     : 17'($urandom_range(0, 76799));
                    host_write(ra, 12'($urandom));
                end else begin
                    tick();
                end
            end
        end

`ifndef VRAM_CLEAR_EN
        // Without the sequencer clr_start must not delay a write
        xpos = 10'd700; ypos = 10'd100;
        clr_start = 1'b1; clr_color = 12'hF00;
        host_write(17'd11, 12'h0B0);
        clr_start = 1'b0;
        chk("noclr_busy", clr_busy, 0);
        chk("noclr_mem", ram_mem[11], 12'h0B0);
`endif

        // Reset asserted during the ACK cycle
        xpos = 10'd700; ypos = 10'd100;
        wr_req = 1'b1; wr_addr = 17'd12; wr_data = 12'h321;
        @(posedge clk); #1;
        chk("mid_ack_pre", wr_ack, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_ack_ack", wr_ack, 0);
        chk("mid_ack_we", ram_we, 0);
        chk("mid_ack_addr", ram_addr, 0);
        wr_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_at = -1;
        sync_pixels();
        repeat (4) tick();

`ifdef VRAM_CLEAR_EN
        // Full clear in vblank with a competing host write
        xpos = 10'd700; ypos = 10'd490;
        wr_req = 1'b1; wr_addr = 17'd9; wr_data = 12'h0AA;
        clr_start = 1'b1; clr_color = 12'hF00;
        @(posedge clk); #1;
        clr_start = 1'b0; clr_color = 12'h00F;
        chk("clr_busy_rise", clr_busy, 1);
        got = 0; errs = 0;
        begin
            int early_ack;
            int done;
            early_ack = 0; done = 0;
            for (int i = 0; i < 80000; i++) begin
                if (wr_ack) early_ack++;
                if (ram_we) begin
                    if (ram_addr != 17'(got) || ram_din != 12'hF00) errs++;
                    got++;
                end
                if (!clr_busy) begin
                    done = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            chk("clr_done", done, 1);
            chk("clr_early_ack", early_ack, 0);
        end
        chk("clr_count", got, FB);
        chk("clr_seq_errs", errs, 0);
        got = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (wr_ack) begin
                got = k;
                chk("clr_post_wr", {ram_we, 3'b0, ram_addr, ram_din}, {1'b1, 3'b0, 17'd9, 12'h0AA});
                break;
            end
        end
        chk("clr_post_ack_lat", (got >= 1 && got <= 2), 1);
        wr_req = 1'b0;
        @(posedge clk); #1;
        chk("clr_no_double", ram_we, 0);
        errs = 0;
        for (int i = 0; i < FB; i++) begin
            ref_mem[i] = (i == 9) ? 12'h0AA : 12'hF00;
            if (ram_mem[i] != ref_mem[i]) errs++;
        end
        chk("clr_mem", errs, 0);
        ack_at = -1;
        sync_pixels();
        xpos = 10'd0; ypos = 10'd0;
        repeat (30) tick();

        // Reset while the clear counter is at 1000
        xpos = 10'd700; ypos = 10'd490;
        clr_start = 1'b1; clr_color = 12'h0F0;
        @(posedge clk); #1;
        clr_start = 1'b0;
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            if (ram_we && ram_addr == 17'd1000) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("clr2_reach_1000", got, 1);
        chk("clr2_color", ram_din, 12'h0F0);
        rst_n = 1'b0;
        #1;
        chk("clr2_busy", clr_busy, 0);
        chk("clr2_we", ram_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        errs = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ram_we || clr_busy) errs++;
        end
        chk("clr2_stopped", errs, 0);
        chk("clr2_pix", pix_data, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
